// File: rtl/calc_core_fsm.sv
// Sequential 8-bit calculator: ADD/SUB in one EXEC cycle, shift-add MUL over 8 ITER cycles.
// Optional restoring divider for op=11 is built only when CALC_DIV_EN is defined.
module calc_core_fsm (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  a_in,
  input  logic [7:0]  b_in,
  input  logic [1:0]  op,
  input  logic        start,
  input  logic        clr,
  output logic [15:0] result,
  output logic        busy,
  output logic        done,
  output logic        neg,
  output logic        err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_ITER = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

`ifdef CALC_DIV_EN
  localparam logic [15:0] DIV_ERR_RES = 16'hFFFF;
`else
  localparam logic [15:0] DIV_ERR_RES = 16'h0000;
`endif

  state_t      r_state;
  logic [7:0]  r_a, r_b;
  logic [1:0]  r_op;
  logic [3:0]  r_cnt;
  logic [15:0] r_acc, r_mcand;
  logic [7:0]  r_mplier;
  logic [15:0] r_result;
  logic        r_busy, r_done, r_neg, r_err;

  logic [15:0] w_sum, w_diff, w_acc_next, w_iter_res;
  logic        w_iter_last, w_go_iter;

  assign w_sum       = {8'h00, r_a} + {8'h00, r_b};
  assign w_diff      = {8'h00, r_a} - {8'h00, r_b};
  assign w_acc_next  = r_acc + (r_mplier[0] ? r_mcand : 16'h0000);
  assign w_iter_last = (r_cnt == 4'd7);

`ifdef CALC_DIV_EN
  // Restoring divider: dividend bits shift out of r_quo MSB into the partial remainder,
  // quotient bits shift in at the LSB.
  logic [7:0] r_rem, r_quo;
  logic [8:0] w_div_shift;
  logic       w_div_ge;
  logic [7:0] w_div_sub, w_rem_next, w_quo_next;

  assign w_div_shift = {r_rem, r_quo[7]};
  assign w_div_ge    = (w_div_shift >= {1'b0, r_b});
  assign w_div_sub   = w_div_shift[7:0] - r_b;
  assign w_rem_next  = w_div_ge ? w_div_sub : w_div_shift[7:0];
  assign w_quo_next  = {r_quo[6:0], w_div_ge};
  assign w_iter_res  = (r_op == OP_DIV) ? {w_rem_next, w_quo_next} : w_acc_next;
  assign w_go_iter   = (op == OP_MUL) || ((op == OP_DIV) && (b_in != 8'h00));
`else
  assign w_iter_res  = w_acc_next;
  assign w_go_iter   = (op == OP_MUL);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_a      <= 8'h00;
      r_b      <= 8'h00;
      r_op     <= OP_ADD;
      r_cnt    <= 4'd0;
      r_acc    <= 16'h0000;
      r_mcand  <= 16'h0000;
      r_mplier <= 8'h00;
      r_result <= 16'h0000;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_neg    <= 1'b0;
      r_err    <= 1'b0;
`ifdef CALC_DIV_EN
      r_rem    <= 8'h00;
      r_quo    <= 8'h00;
`endif
    end else if (clr) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_result <= 16'h0000;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_neg    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a      <= a_in;
            r_b      <= b_in;
            r_op     <= op;
            r_cnt    <= 4'd0;
            r_acc    <= 16'h0000;
            r_mcand  <= {8'h00, a_in};
            r_mplier <= b_in;
            r_neg    <= 1'b0;
            r_err    <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= w_go_iter ? S_ITER : S_EXEC;
`ifdef CALC_DIV_EN
            r_rem    <= 8'h00;
            r_quo    <= a_in;
`endif
          end
        end
        S_EXEC: begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
          case (r_op)
            OP_ADD: r_result <= w_sum;
            OP_SUB: begin
              r_result <= w_diff;
              r_neg    <= (r_a < r_b);
            end
            // Only DIV lands here: unsupported, or divide by zero.
            default: begin
              r_result <= DIV_ERR_RES;
              r_err    <= 1'b1;
            end
          endcase
        end
        S_ITER: begin
          r_cnt    <= r_cnt + 4'd1;
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
`ifdef CALC_DIV_EN
          r_rem    <= w_rem_next;
          r_quo    <= w_quo_next;
`endif
          if (w_iter_last) begin
            r_result <= w_iter_res;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_cnt   <= 4'd0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign result = r_result;
  assign busy   = r_busy;
  assign done   = r_done;
  assign neg    = r_neg;
  assign err    = r_err;

endmodule
